// File: rtl/trace_pkg.sv
// rtl/trace_pkg.sv - shared types and constants for the cpu trace monitor
package trace_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE    = 2'd2,
    TIMEOUT = 2'd3
  } mon_state_t;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } store_rec_t;

  localparam logic [31:0] FINISH_PC_RST = 32'hFFFF_FFFF;

endpackage

// File: rtl/trace_fifo.sv
// rtl/trace_fifo.sv - store-log FIFO with sticky overflow flag
// Head entry is read straight from storage; a full FIFO still accepts a push when popped that cycle.
module trace_fifo
  import trace_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clear,
  input  logic       push,
  input  store_rec_t push_rec,
  input  logic       pop,
  output store_rec_t head_rec,
  output logic       full,
  output logic       empty,
  output logic       ovf
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = {{AW{1'b0}}, 1'b1};

  store_rec_t  mem_q [DEPTH];
  logic [AW:0] wr_ptr_q, wr_ptr_d;
  logic [AW:0] rd_ptr_q, rd_ptr_d;
  logic        ovf_q, ovf_d;
  logic        pop_ok, push_ok;

  assign empty    = (wr_ptr_q == rd_ptr_q);
  assign full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign pop_ok   = pop & ~empty;
  assign push_ok  = push & (~full | pop_ok);
  assign head_rec = mem_q[rd_ptr_q[AW-1:0]];
  assign ovf      = ovf_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    ovf_d    = ovf_q;
    if (clear) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PTR_ONE;
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_ONE;
      if (push && !push_ok) ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      ovf_q    <= ovf_d;
    end
  end

  // Storage needs no reset: contents are only visible through the pointers.
  always_ff @(posedge clk) begin
    if (push_ok && !clear && !reset) begin
      mem_q[wr_ptr_q[AW-1:0]] <= push_rec;
    end
  end

endmodule

// File: rtl/cpu_trace_monitor.sv
// rtl/cpu_trace_monitor.sv - run monitor for the pipelined mips core: finish-PC gating, CPI counters, store log
// Optional watchdog and TIMEOUT state built when TRACE_WDOG_EN is defined.
module cpu_trace_monitor
  import trace_pkg::*;
#(
  parameter int LOG_DEPTH = 8,
  parameter int CNT_W     = 32,
  parameter int WDOG_MAX  = 1000000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [31:0]      finish_pc,
  input  logic [31:0]      pc,
  input  logic             memwrite,
  input  logic [31:0]      aluout,
  input  logic [31:0]      writedata,
  input  logic             stallD,
  input  logic             flushD,
  output logic             cpu_en,
  output logic             mem_we,
  output logic             done,
  output logic             timeout,
  output logic [CNT_W-1:0] cycle_cnt,
  output logic [CNT_W-1:0] instr_cnt,
  output logic             log_valid,
  input  logic             log_ready,
  output logic [31:0]      log_addr,
  output logic [31:0]      log_data,
  output logic             log_ovf
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  mon_state_t       state_q, state_d;
  logic [31:0]      finish_pc_q, finish_pc_d;
  logic [CNT_W-1:0] cycle_cnt_q, cycle_cnt_d;
  logic [CNT_W-1:0] instr_cnt_q, instr_cnt_d;
  logic             count_en;
  logic             wdog_hit;
  logic             fifo_full, fifo_empty;
  store_rec_t       push_rec, head_rec;

  assign cpu_en   = (state_q == RUN) && (pc != finish_pc_q);
  assign mem_we   = memwrite & cpu_en;
  // A start cycle only re-arms the monitor; nothing is counted or logged in it.
  assign count_en = cpu_en & ~start;

`ifdef TRACE_WDOG_EN
  localparam int WD_W = $clog2(WDOG_MAX + 1);
  localparam logic [WD_W-1:0] WD_ONE = {{(WD_W-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0] WD_LIM = WD_W'(WDOG_MAX);

  logic [WD_W-1:0] wdog_q, wdog_d;

  always_comb begin
    wdog_d = wdog_q;
    if (start)         wdog_d = '0;
    else if (count_en) wdog_d = wdog_q + WD_ONE;
  end

  assign wdog_hit = count_en && (wdog_d == WD_LIM);
  assign timeout  = (state_q == TIMEOUT);

  always_ff @(posedge clk) begin
    if (reset) wdog_q <= '0;
    else       wdog_q <= wdog_d;
  end
`else
  assign wdog_hit = 1'b0;
  // Without the watchdog the limit has no effect; the comparison only folds away.
  assign timeout  = (WDOG_MAX < 0);
`endif

  always_comb begin
    state_d     = state_q;
    finish_pc_d = finish_pc_q;
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (start) begin
      state_d     = RUN;
      finish_pc_d = finish_pc;
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      if (count_en) begin
        if (cycle_cnt_q != '1) cycle_cnt_d = cycle_cnt_q + CNT_ONE;
        if (!stallD && !flushD && instr_cnt_q != '1) instr_cnt_d = instr_cnt_q + CNT_ONE;
      end
      if (state_q == RUN && pc == finish_pc_q) state_d = DONE;
      else if (state_q == RUN && wdog_hit)     state_d = TIMEOUT;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      finish_pc_q <= FINISH_PC_RST;
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      finish_pc_q <= finish_pc_d;
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign done      = (state_q == DONE);
  assign cycle_cnt = cycle_cnt_q;
  assign instr_cnt = instr_cnt_q;

  assign push_rec.addr = aluout;
  assign push_rec.data = writedata;

  trace_fifo #(
    .DEPTH (LOG_DEPTH)
  ) u_fifo (
    .clk      (clk),
    .reset    (reset),
    .clear    (start),
    .push     (mem_we & ~start),
    .push_rec (push_rec),
    .pop      (log_ready),
    .head_rec (head_rec),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .ovf      (log_ovf)
  );

  assign log_valid = ~fifo_empty;
  assign log_addr  = head_rec.addr;
  assign log_data  = head_rec.data;

endmodule
